mul8_seq_ctrl: RTL and testbench



---
 rtl/mul8_seq_pkg.sv | 31 +++
 rtl/mul8_seq_ctrl_ap.sv | 50 +++++
 rtl/mul8_seq_ctrl_ap4x4_sel.sv | 26 ++
 rtl/mul8_seq_ctrl.sv | 120 ++++++++++++
 tb/tb_mul8_seq_ctrl.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/mul8_seq_pkg.sv
// Shared types and constants for the sequenced 8x8 approximate multiplier.
// Mode codes select the variant used for each 4x4 partial product.
package mul8_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P_LL = 3'd1,
    P_LH = 3'd2,
    P_HL = 3'd3,
    P_HH = 3'd4,
    DONE = 3'd5
  } state_e;

  localparam logic [1:0] MODE_EXACT = 2'd0;
  localparam logic [1:0] MODE_AP1   = 2'd1;
  localparam logic [1:0] MODE_AP3   = 2'd2;
  localparam logic [1:0] MODE_AP4   = 2'd3;

  // HH=ap1, HL=ap3, LH=ap3, LL=ap4
  localparam logic [7:0] CFG_1334 = 8'h6B;

  localparam int CFG_LL_OFS = 0;
  localparam int CFG_LH_OFS = 2;
  localparam int CFG_HL_OFS = 4;
  localparam int CFG_HH_OFS = 6;

  function automatic logic [15:0] sat16(input logic [16:0] v);
    return v[16] ? 16'hFFFF : v[15:0];
  endfunction

endpackage

// File: rtl/mul8_seq_ctrl_ap.sv
// Approximate 4x4 multipliers built from four 2x2 blocks; apN replaces N blocks
// (LL first, then LH/HL, then HH) with the 3-bit 2x2 cell where 3*3 yields 7.
module ap4x4_core #(
  parameter logic [3:0] APPROX = 4'b0000  // [0]=LL [1]=LH [2]=HL [3]=HH
) (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0][3:0] pp;

  for (genvar i = 0; i < 4; i++) begin : g_blk
    localparam int AI = (i / 2) * 2;
    localparam int BI = (i % 2) * 2;
    logic [1:0] x, y;
    assign x = a[AI +: 2];
    assign y = b[BI +: 2];
    if (APPROX[i]) begin : g_apx
      assign pp[i] = {1'b0, x[1] & y[1], (x[1] & y[0]) | (x[0] & y[1]), x[0] & y[0]};
    end else begin : g_exact
      assign pp[i] = {2'b00, x} * {2'b00, y};
    end
  end

  assign p = {4'b0, pp[0]} + {2'b0, pp[1], 2'b0} + {2'b0, pp[2], 2'b0} + {pp[3], 4'b0};
endmodule

module ap1 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  ap4x4_core #(.APPROX(4'b0001)) u_core (.a(a), .b(b), .p(p));
endmodule

module ap3 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  ap4x4_core #(.APPROX(4'b0111)) u_core (.a(a), .b(b), .p(p));
endmodule

module ap4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  ap4x4_core #(.APPROX(4'b1111)) u_core (.a(a), .b(b), .p(p));
endmodule

// File: rtl/mul8_seq_ctrl_ap4x4_sel.sv
// Mode-selectable 4x4 multiplier: exact or one of the ap1/ap3/ap4 variants.
module ap4x4_sel
  import mul8_seq_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [1:0] mode,
  output logic [7:0] p
);
  logic [7:0] p_ex, p_ap1, p_ap3, p_ap4;

  assign p_ex = {4'b0, a} * {4'b0, b};

  ap1 u_ap1 (.a(a), .b(b), .p(p_ap1));
  ap3 u_ap3 (.a(a), .b(b), .p(p_ap3));
  ap4 u_ap4 (.a(a), .b(b), .p(p_ap4));

  always_comb begin
    case (mode)
      MODE_EXACT: p = p_ex;
      MODE_AP1:   p = p_ap1;
      MODE_AP3:   p = p_ap3;
      default:    p = p_ap4;
    endcase
  end
endmodule

// File: rtl/mul8_seq_ctrl.sv
// Sequenced 8x8 approximate multiplier: four 4x4 partials through one shared
// sub-multiplier, exact shift-add into a 17-bit accumulator, saturated to 16 bits.
module mul8_seq_ctrl
  import mul8_seq_pkg::*;
#(
  parameter logic [7:0] CFG_RST = CFG_1334
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic [7:0]  cfg,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] prod,
  output logic        busy
);
  state_e      state_q, state_d;
  logic [7:0]  a_q, a_d, b_q, b_d, cfg_q, cfg_d;
  logic [16:0] acc_q, acc_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] prod_q, prod_d;

  logic [3:0]  sub_a, sub_b, sh;
  logic [1:0]  sub_mode;
  logic [7:0]  pp;
  logic [16:0] term;
  logic        accept, xfer;

  assign accept = in_valid & in_ready_q;
  assign xfer   = out_valid_q & out_ready;

  // Operand nibbles, mode field and shift all follow the current state.
  always_comb begin
    sub_a    = a_q[3:0];
    sub_b    = b_q[3:0];
    sub_mode = cfg_q[CFG_LL_OFS +: 2];
    sh       = 4'd0;
    case (state_q)
      P_LH: begin
        sub_b    = b_q[7:4];
        sub_mode = cfg_q[CFG_LH_OFS +: 2];
        sh       = 4'd4;
      end
      P_HL: begin
        sub_a    = a_q[7:4];
        sub_mode = cfg_q[CFG_HL_OFS +: 2];
        sh       = 4'd4;
      end
      P_HH: begin
        sub_a    = a_q[7:4];
        sub_b    = b_q[7:4];
        sub_mode = cfg_q[CFG_HH_OFS +: 2];
        sh       = 4'd8;
      end
      default: ;
    endcase
  end

  ap4x4_sel u_sub (.a(sub_a), .b(sub_b), .mode(sub_mode), .p(pp));

  assign term = 17'(pp) << sh;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cfg_d   = cfg_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: if (accept) begin
        a_d     = a;
        b_d     = b;
        cfg_d   = cfg;
        acc_d   = '0;
        state_d = P_LL;
      end
      P_LL: begin acc_d = acc_q + term; state_d = P_LH; end
      P_LH: begin acc_d = acc_q + term; state_d = P_HL; end
      P_HL: begin acc_d = acc_q + term; state_d = P_HH; end
      P_HH: begin acc_d = acc_q + term; state_d = DONE; end
      DONE: if (xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    // First DONE cycle registers the saturated result; out_valid follows it.
    out_valid_d = (state_q == DONE) && !xfer;
    prod_d      = ((state_q == DONE) && !out_valid_q) ? sat16(acc_q) : prod_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cfg_q       <= CFG_RST;
      acc_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      prod_q      <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cfg_q       <= cfg_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      prod_q      <= prod_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign prod      = prod_q;
  assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Directed and random checks of mul8_seq_ctrl against an independent
// error-term model of the ap1/ap3/ap4 cells, with a result scoreboard.
module tb_mul8_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a = '0, b = '0, cfg = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] prod;
  logic        busy;

  int n_cmp = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  mul8_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cfg(cfg), .out_valid(out_valid), .out_ready(out_ready),
    .prod(prod), .busy(busy)
  );

  // Approximate cells modelled as exact product minus 2 per approximated
  // 2x2 block whose two operand bit-pairs are both 3, scaled by block weight.
  function automatic logic [7:0] m_sub(input logic [3:0] x, input logic [3:0] y,
                                       input logic [1:0] md);
    int e = int'(x) * int'(y);
    int err = 0;
    if (md != 2'd0 && x[1:0] == 2'b11 && y[1:0] == 2'b11) err += 2;
    if (md >= 2'd2 && x[1:0] == 2'b11 && y[3:2] == 2'b11) err += 8;
    if (md >= 2'd2 && x[3:2] == 2'b11 && y[1:0] == 2'b11) err += 8;
    if (md == 2'd3 && x[3:2] == 2'b11 && y[3:2] == 2'b11) err += 32;
    return 8'(e - err);
  endfunction

  function automatic logic [15:0] m_mul8(input logic [7:0] x, input logic [7:0] y,
                                         input logic [7:0] c);
    logic [16:0] acc;
    acc = 17'(m_sub(x[3:0], y[3:0], c[1:0]))
        + (17'(m_sub(x[3:0], y[7:4], c[3:2])) << 4)
        + (17'(m_sub(x[7:4], y[3:0], c[5:4])) << 4)
        + (17'(m_sub(x[7:4], y[7:4], c[7:6])) << 8);
    return acc[16] ? 16'hFFFF : acc[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction: accept, measure latency, optional backpressure with
  // ignored in_valid pokes, then transfer and scoreboard compare.
  task automatic run_txn(input logic [7:0] ta, input logic [7:0] tb, input logic [7:0] tc,
                         input int hold, input bit toggle);
    int cyc;
    logic busy_ok;
    logic [15:0] held, e;
    cyc = 0;
    while (!in_ready && cyc < 20) begin step(); cyc++; end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    a = ta; b = tb; cfg = tc; in_valid = 1'b1;
    exp_q.push_back(m_mul8(ta, tb, tc));
    step();
    in_valid = 1'b0;
    if (toggle) begin cfg = ~tc; a = ~ta; b = ~tb; end
    busy_ok = 1'b1;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      busy_ok &= busy;
      step();
      cyc++;
    end
    chk("latency", 32'(cyc), 32'd5);
    chk("busy_span", 32'(busy_ok & busy), 32'd1);
    held = prod;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = 8'h55; b = 8'hAA;
      step();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_prod_stable", 32'(prod), 32'(held));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    chk("sb_depth", 32'(exp_q.size()), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("prod", 32'(prod), 32'(e));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("in_ready_after_xfer", 32'(in_ready), 32'd1);
    chk("out_valid_after_xfer", 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic ov_seen;
    logic [7:0] ra, rb;
    // Reset state
    step(); step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_prod", 32'(prod), 32'd0);
    rst_n = 1'b1;
    chk("in_ready_pre_clk", 32'(in_ready), 32'd0);
    step();
    chk("in_ready_first_clk", 32'(in_ready), 32'd1);

    // Directed exact cases, one with backpressure and in_valid pokes
    run_txn(8'hFF, 8'hFF, 8'h00, 0, 1'b0);
    run_txn(8'h12, 8'h34, 8'h00, 3, 1'b0);
    run_txn(8'h00, 8'hAB, 8'h00, 0, 1'b0);
    run_txn(8'hFF, 8'hFF, 8'hFF, 2, 1'b1);
    chk("ap4_ff_ff_model", 32'(m_mul8(8'hFF, 8'hFF, 8'hFF)), 32'(m_mul8(8'hFF, 8'hFF, 8'hFF)) & 32'hFFFF);

    // Random traffic with the 1334 config, cfg/operands disturbed mid-flight
    for (int i = 0; i < 10000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_txn(ra, rb, 8'h6B, 0, i[0]);
    end

    // Reset during P_HL drops the transaction
    a = 8'hAA; b = 8'h55; cfg = 8'h00; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_prod", 32'(prod), 32'd0);
    step();
    rst_n = 1'b1;
    ov_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      ov_seen |= out_valid;
    end
    chk("midrst_no_out_valid", 32'(ov_seen), 32'd0);
    chk("midrst_idle", 32'(busy), 32'd0);
    chk("midrst_prod_after", 32'(prod), 32'd0);
    run_txn(8'h0F, 8'h0F, 8'h00, 0, 1'b0);
    chk("const_e1", 32'(m_mul8(8'h0F, 8'h0F, 8'h00)), 32'h00E1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule
